// File: rtl/matrix_stream_arbiter.sv
// Two-requester round-robin arbiter that streams whole SIZE x SIZE matrices
// onto one output, dropping elements outside the per-grant triangular/diagonal mask.
module matrix_stream_arbiter #(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [1:0]            mode0,
    input  logic [1:0]            mode1,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tsrc,
    output logic                  busy
);

    localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  w_grant_nxt;
    logic                  w_grant_load;
    logic [1:0]            r_mode;
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic                  r_m_tsrc;
    logic                  w_can_accept;
    logic                  w_in_valid;
    logic                  w_accept;
    logic                  w_at_last;
    logic                  w_pass;
    logic [DATA_WIDTH-1:0] w_in_data;

    // Input side may only advance when the output register is free or draining.
    assign w_can_accept = (r_state == BUSY) && (!r_m_tvalid || m_tready);
    assign w_in_valid   = r_grant ? s1_tvalid : s0_tvalid;
    assign w_in_data    = r_grant ? s1_tdata : s0_tdata;
    assign w_accept     = w_can_accept && w_in_valid;
    assign w_at_last    = (r_row == LAST_IDX) && (r_col == LAST_IDX);

    assign s0_tready = w_can_accept && !r_grant;
    assign s1_tready = w_can_accept && r_grant;
    assign busy      = (r_state == BUSY);
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign m_tsrc    = r_m_tsrc;

    // Mask test for the element currently being accepted.
    always_comb begin
        w_pass = 1'b1;
        case (r_mode)
            2'b00:   w_pass = 1'b1;
            2'b01:   w_pass = (r_row >= r_col);
            2'b10:   w_pass = (r_row <= r_col);
            default: w_pass = (r_row == r_col);
        endcase
    end

    // Next-state and grant selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_grant_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    w_state_nxt  = BUSY;
                    w_grant_load = 1'b1;
                    if (s0_tvalid && s1_tvalid) begin
                        w_grant_nxt = ~r_last_grant;
                    end else begin
                        w_grant_nxt = s1_tvalid;
                    end
                end
            end
            BUSY: begin
                if (w_accept && w_at_last) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, latched mode and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_mode       <= 2'b00;
            r_last_grant <= 1'b1;
        end else begin
            if (w_grant_load) begin
                r_grant <= w_grant_nxt;
                r_mode  <= w_grant_nxt ? mode1 : mode0;
            end
            if (w_accept && w_at_last) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Row-major element position, column fastest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == LAST_IDX) ? '0 : r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Output register; masked elements are consumed with valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tsrc   <= 1'b0;
        end else if (w_accept) begin
            r_m_tdata  <= w_in_data;
            r_m_tvalid <= w_pass;
            r_m_tlast  <= w_at_last;
            r_m_tsrc   <= r_grant;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_stream_arbiter.sv
// Directed bench for matrix_stream_arbiter: masks, round-robin, backpressure,
// mid-matrix reset, mode latching, plus a SIZE=1 instance.
module tb_matrix_stream_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        src;
        int          cyc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_tdata, s1_tdata, m_tdata;
    logic        s0_tvalid, s0_tready, s1_tvalid, s1_tready;
    logic [1:0]  mode0, mode1;
    logic        m_tvalid, m_tready, m_tlast, m_tsrc, busy;

    logic [7:0]  p_s0_tdata, p_s1_tdata, p_m_tdata;
    logic        p_s0_tvalid, p_s0_tready, p_s1_tvalid, p_s1_tready;
    logic [1:0]  p_mode0, p_mode1;
    logic        p_m_tvalid, p_m_tready, p_m_tlast, p_m_tsrc, p_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   s0_left  = 0;
    int   s1_left  = 0;
    int   acc0     = 0;
    int   acc1     = 0;
    out_t q[$];
    int   acc0_cyc[$];

    always #5 clk = ~clk;

    matrix_stream_arbiter #(.SIZE(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .mode0(mode0), .mode1(mode1),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tsrc(m_tsrc), .busy(busy)
    );

    matrix_stream_arbiter #(.SIZE(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst),
        .s0_tdata(p_s0_tdata), .s0_tvalid(p_s0_tvalid), .s0_tready(p_s0_tready),
        .s1_tdata(p_s1_tdata), .s1_tvalid(p_s1_tvalid), .s1_tready(p_s1_tready),
        .mode0(p_mode0), .mode1(p_mode1),
        .m_tdata(p_m_tdata), .m_tvalid(p_m_tvalid), .m_tready(p_m_tready),
        .m_tlast(p_m_tlast), .m_tsrc(p_m_tsrc), .busy(p_busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: records every completed output handshake.
    initial forever begin
        @(negedge clk);
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            q.push_back('{m_tdata, m_tlast, m_tsrc, cyc});
        end
    end

    // Source models: incrementing data, s*_left elements remaining.
    initial begin
        logic a0, a1;
        forever begin
            @(negedge clk);
            a0 = (s0_tvalid === 1'b1) && (s0_tready === 1'b1);
            a1 = (s1_tvalid === 1'b1) && (s1_tready === 1'b1);
            if (a0) acc0_cyc.push_back(cyc);
            @(posedge clk);
            #2;
            if (a0) begin
                acc0++;
                s0_tdata = s0_tdata + 32'd1;
                if (s0_left > 0) s0_left--;
            end
            if (a1) begin
                acc1++;
                s1_tdata = s1_tdata + 32'd1;
                if (s1_left > 0) s1_left--;
            end
            s0_tvalid = (s0_left != 0);
            s1_tvalid = (s1_left != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int n, input string tag);
        int budget;
        budget = 2000;
        while (q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d outputs, need %0d", tag, q.size(), n);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m_tvalid, m_tlast, m_tsrc, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v/l/s/b=%b%b%b%b, need 0000", m_tvalid, m_tlast, m_tsrc, busy);
        end
        n_checks++;
        if (m_tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, need 0", m_tdata);
        end
        n_checks++;
        if ({s0_tready, s1_tready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_tready: got %b%b, need 00", s0_tready, s1_tready);
        end
        n_checks++;
        if ({p_m_tvalid, p_busy, p_m_tdata} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_size1: got v=%b b=%b d=%h, need 0", p_m_tvalid, p_busy, p_m_tdata);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy got %b, need 0", busy);
        end
    endtask

    task automatic test_size1();
        step();
        p_mode0     = 2'b11;
        p_m_tready  = 1'b1;
        p_s0_tdata  = 8'hA5;
        p_s0_tvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (p_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL size1_pre_grant: busy got %b, need 0", p_busy);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({p_busy, p_s0_tready, p_s1_tready, p_m_tvalid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL size1_grant: b/r0/r1/v got %b%b%b%b, need 1100", p_busy, p_s0_tready, p_s1_tready, p_m_tvalid);
        end
        step();
        p_s0_tvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({p_m_tvalid, p_m_tlast, p_m_tsrc, p_busy, p_m_tdata} !== {4'b1100, 8'hA5}) begin
            n_fail++;
            $display("FAIL size1_out: v/l/s/b got %b%b%b%b data %h, need 1100 data a5", p_m_tvalid, p_m_tlast, p_m_tsrc, p_busy, p_m_tdata);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({p_m_tvalid, p_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL size1_drain: v/b got %b%b, need 00", p_m_tvalid, p_busy);
        end
    endtask

    task automatic test_full();
        q.delete();
        acc0_cyc.delete();
        mode0    = 2'b00;
        m_tready = 1'b1;
        step();
        s0_tdata = 32'd1;
        s0_left  = 16;
        wait_outputs(16, "full");
        n_checks++;
        if (q.size() != 16) begin
            n_fail++;
            $display("FAIL full_count: got %0d, need 16", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            n_checks++;
            if (q[i].data !== 32'(i + 1) || q[i].src !== 1'b0 || q[i].last !== (i == 15)) begin
                n_fail++;
                $display("FAIL full_elem[%0d]: got d=%0d s=%b l=%b, need d=%0d s=0 l=%b", i, q[i].data, q[i].src, q[i].last, i + 1, (i == 15));
            end
        end
        n_checks++;
        if (q.size() == 0 || acc0_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL full_latency: no accept/output observed");
        end else if (q[0].cyc != acc0_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL full_latency: output cycle %0d, need %0d", q[0].cyc, acc0_cyc[0] + 1);
        end
    endtask

    task automatic test_masks();
        int exp_tab[3][10];
        int exp_n[3];
        exp_tab[0] = '{1, 5, 6, 9, 10, 11, 13, 14, 15, 16};
        exp_tab[1] = '{1, 2, 3, 4, 6, 7, 8, 11, 12, 16};
        exp_tab[2] = '{1, 6, 11, 16, 0, 0, 0, 0, 0, 0};
        exp_n      = '{10, 10, 4};
        for (int m = 0; m < 3; m++) begin
            q.delete();
            mode0 = 2'(m + 1);
            step();
            s0_tdata = 32'd1;
            s0_left  = 16;
            wait_outputs(exp_n[m], "mask");
            n_checks++;
            if (q.size() != exp_n[m]) begin
                n_fail++;
                $display("FAIL mask%0d_count: got %0d, need %0d", m + 1, q.size(), exp_n[m]);
            end
            for (int i = 0; i < q.size() && i < exp_n[m]; i++) begin
                n_checks++;
                if (q[i].data !== 32'(exp_tab[m][i]) || q[i].src !== 1'b0 || q[i].last !== (i == exp_n[m] - 1)) begin
                    n_fail++;
                    $display("FAIL mask%0d_elem[%0d]: got d=%0d l=%b, need d=%0d l=%b", m + 1, i, q[i].data, q[i].last, exp_tab[m][i], (i == exp_n[m] - 1));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int k;
        int exp_d;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        mode0    = 2'b00;
        mode1    = 2'b00;
        s0_tdata = 32'd1;
        s1_tdata = 32'd101;
        s0_left  = 32;
        s1_left  = 32;
        wait_outputs(64, "round_robin");
        n_checks++;
        if (q.size() != 64) begin
            n_fail++;
            $display("FAIL rr_count: got %0d, need 64", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            k     = i / 16;
            exp_d = ((k % 2) == 0 ? 1 : 101) + (k / 2) * 16 + (i % 16);
            n_checks++;
            if (q[i].data !== 32'(exp_d) || q[i].src !== 1'(k % 2) || q[i].last !== ((i % 16) == 15)) begin
                n_fail++;
                $display("FAIL rr_elem[%0d]: got d=%0d s=%b l=%b, need d=%0d s=%0d", i, q[i].data, q[i].src, q[i].last, exp_d, k % 2);
            end
            if (i > 0) begin
                n_checks++;
                if (q[i].cyc - q[i-1].cyc != ((i % 16) == 0 ? 2 : 1)) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: got %0d cycles, need %0d", i, q[i].cyc - q[i-1].cyc, (i % 16) == 0 ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int budget;
        q.delete();
        mode0 = 2'b00;
        step();
        s0_tdata = 32'd1;
        s0_left  = 16;
        budget   = 200;
        while (q.size() < 5 && budget > 0) begin
            step();
            budget--;
        end
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({m_tvalid, m_tlast, m_tsrc, s0_tready} !== 4'b1000 || m_tdata !== 32'd6) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v/l/s/rdy=%b%b%b%b d=%0d, need 1000 d=6", c, m_tvalid, m_tlast, m_tsrc, s0_tready, m_tdata);
            end
        end
        step();
        m_tready = 1'b1;
        wait_outputs(16, "backpressure");
        n_checks++;
        if (q.size() != 16) begin
            n_fail++;
            $display("FAIL bp_count: got %0d, need 16", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            n_checks++;
            if (q[i].data !== 32'(i + 1) || q[i].last !== (i == 15)) begin
                n_fail++;
                $display("FAIL bp_elem[%0d]: got d=%0d l=%b, need d=%0d", i, q[i].data, q[i].last, i + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int budget;
        q.delete();
        mode1 = 2'b00;
        step();
        s1_tdata = 32'd201;
        s1_left  = 16;
        base     = acc1;
        budget   = 200;
        while (acc1 - base < 7 && budget > 0) begin
            @(posedge clk);
            #3;
            budget--;
        end
        rst       = 1'b1;
        s1_left   = 0;
        s1_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m_tvalid, m_tlast, m_tsrc, busy, s0_tready, s1_tready} !== 6'd0 || m_tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got v/l/s/b/r0/r1=%b%b%b%b%b%b d=%0d, need all 0", m_tvalid, m_tlast, m_tsrc, busy, s0_tready, s1_tready, m_tdata);
        end
        step();
        rst = 1'b0;
        q.delete();
        mode0    = 2'b00;
        s0_tdata = 32'd1;
        s1_tdata = 32'd301;
        s0_left  = 16;
        s1_left  = 16;
        wait_outputs(32, "reset_mid");
        n_checks++;
        if (q.size() != 32) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d, need 32", q.size());
        end
        for (int i = 0; i < q.size() && i < 16; i++) begin
            n_checks++;
            if (q[i].data !== 32'(i + 1) || q[i].src !== 1'b0 || q[i].last !== (i == 15)) begin
                n_fail++;
                $display("FAIL midrst_elem[%0d]: got d=%0d s=%b l=%b, need d=%0d s=0", i, q[i].data, q[i].src, q[i].last, i + 1);
            end
        end
        n_checks++;
        if (q.size() < 17 || q[16].data !== 32'd301 || q[16].src !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_second: got size=%0d, need s1 element 301 at index 16", q.size());
        end
    endtask

    task automatic test_mode_change();
        int exp_d[26];
        int base;
        int budget;
        exp_d = '{1, 5, 6, 9, 10, 11, 13, 14, 15, 16,
                  17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32};
        q.delete();
        mode0 = 2'b01;
        step();
        s0_tdata = 32'd1;
        s0_left  = 32;
        base     = acc0;
        budget   = 200;
        while (acc0 - base < 3 && budget > 0) begin
            @(posedge clk);
            #3;
            budget--;
        end
        mode0 = 2'b00;
        wait_outputs(26, "mode_change");
        n_checks++;
        if (q.size() != 26) begin
            n_fail++;
            $display("FAIL modechg_count: got %0d, need 26", q.size());
        end
        for (int i = 0; i < q.size() && i < 26; i++) begin
            n_checks++;
            if (q[i].data !== 32'(exp_d[i]) || q[i].last !== (i == 9 || i == 25)) begin
                n_fail++;
                $display("FAIL modechg_elem[%0d]: got d=%0d l=%b, need d=%0d", i, q[i].data, q[i].last, exp_d[i]);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        s0_tdata    = '0;
        s1_tdata    = '0;
        s0_tvalid   = 1'b0;
        s1_tvalid   = 1'b0;
        mode0       = 2'b00;
        mode1       = 2'b00;
        m_tready    = 1'b1;
        p_s0_tdata  = '0;
        p_s1_tdata  = '0;
        p_s0_tvalid = 1'b0;
        p_s1_tvalid = 1'b0;
        p_mode0     = 2'b00;
        p_mode1     = 2'b00;
        p_m_tready  = 1'b1;

        test_reset();
        test_size1();
        test_full();
        test_masks();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_mode_change();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
